// File: rtl/jtag_wb_bridge_if.sv
// Wishbone pipelined bus bundle for jtag_wb_bridge.
// Signal names keep the original port names, so existing connections map one-to-one.
interface jtag_wb_bridge_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic        wb_ack_o;
  logic        wb_stall_o;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_ack_o, wb_stall_o, wb_dat_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_ack_o, wb_stall_o, wb_dat_o
  );
endinterface

// File: rtl/jtag_wb_bridge.sv
// Wishbone slave that queues debug-register writes for the LM32 JTAG debug core.
// A command FIFO absorbs CPU writes without stalling; a drain FSM issues one
// reg_update_o pulse per entry, spaced G_LATCH_DELAY clocks apart.
// Optional build macro JTAG_WB_SNAPSHOT_EN: registers the core read-back every
// cycle and reports changes in STATUS bit3.
module jtag_wb_bridge #(
  parameter int unsigned G_DEPTH       = 4,
  parameter int unsigned G_LATCH_DELAY = 8,
  parameter int unsigned G_DATA_W      = 8,
  parameter int unsigned G_ADDR_W      = 3
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  jtag_wb_bridge_if.slave     bus,
  input  logic [G_DATA_W-1:0] reg_d_i,
  input  logic [G_ADDR_W-1:0] reg_addr_d_i,
  output logic                reg_update_o,
  output logic [G_DATA_W-1:0] reg_q_o,
  output logic [G_ADDR_W-1:0] reg_addr_q_o,
  output logic                jtck_o,
  output logic                jrstn_o
);
  localparam int unsigned ENT_W = G_DATA_W + G_ADDR_W;
  localparam int unsigned PTR_W = (G_DEPTH > 1) ? $clog2(G_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = (G_LATCH_DELAY > 1) ? $clog2(G_LATCH_DELAY) : 1;

  typedef enum logic [0:0] {S_IDLE, S_HOLD} state_t;

  logic [ENT_W-1:0] mem [G_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             ovf_q;
  logic             ack_q;
  logic [31:0]      dat_q;
  logic [31:0]      rdata;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       acc, full, empty, push, pop, cmd_wr, cmd_rd, drop, ovf_clr;
  logic [1:0] sel;
  logic [ENT_W-1:0] rd_cmd_val;
  logic       chg_bit;
  logic       unused_ok;

  assign acc     = bus.wb_cyc_i & bus.wb_stb_i;
  assign sel     = bus.wb_adr_i[3:2];
  assign full    = (level == LVL_W'(G_DEPTH));
  assign empty   = (level == '0);
  assign cmd_wr  = acc & bus.wb_we_i & (sel == 2'd0);
  assign cmd_rd  = acc & ~bus.wb_we_i & (sel == 2'd0);
  assign push    = cmd_wr & ~full;
  assign drop    = cmd_wr & full;
  assign ovf_clr = acc & bus.wb_we_i & (sel == 2'd1) & bus.wb_dat_i[2];
  assign pop     = (state == S_IDLE) & ~empty;

  assign bus.wb_ack_o   = ack_q;
  assign bus.wb_stall_o = 1'b0;
  assign bus.wb_dat_o   = dat_q;
  assign jtck_o         = clk_i;
  assign unused_ok      = ^{bus.wb_adr_i, bus.wb_dat_i, bus.wb_sel_i};

`ifdef JTAG_WB_SNAPSHOT_EN
  logic [ENT_W-1:0] snap_q;
  logic             snap_chg_q;

  // Capture core read-back every cycle; sticky change flag, cleared by a CMD read
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snap_q     <= '0;
      snap_chg_q <= 1'b0;
    end else begin
      snap_q <= {reg_d_i, reg_addr_d_i};
      if (snap_q != {reg_d_i, reg_addr_d_i}) snap_chg_q <= 1'b1;
      else if (cmd_rd)                       snap_chg_q <= 1'b0;
    end
  end

  assign rd_cmd_val = snap_q;
  assign chg_bit    = snap_chg_q;
`else
  assign rd_cmd_val = {reg_d_i, reg_addr_d_i};
  assign chg_bit    = 1'b0;
`endif

  // Read-data mux for the register map; writes and unmapped slots return 0
  always_comb begin
    rdata = '0;
    if (!bus.wb_we_i) begin
      case (sel)
        2'd0:    rdata = 32'(rd_cmd_val);
        2'd1:    rdata = {16'h0, 8'(level), 4'h0, chg_bit, ovf_q, full, empty};
        default: rdata = '0;
      endcase
    end
  end

  // Wishbone response: one-cycle ack for every accepted request, data only with ack
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= acc ? rdata : '0;
    end
  end

  // FIFO storage; contents are don't-care while the level is zero
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus.wb_dat_i[ENT_W-1:0];
  end

  // FIFO pointers, level and sticky overflow (a new drop beats a W1C clear)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Drain FSM: pop and pulse the core, then hold off for the latch interval
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      reg_update_o <= 1'b0;
      reg_q_o      <= '0;
      reg_addr_q_o <= '0;
    end else begin
      reg_update_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) begin
            reg_update_o <= 1'b1;
            {reg_q_o, reg_addr_q_o} <= mem[rd_ptr];
            cnt   <= CNT_W'(G_LATCH_DELAY - 1);
            state <= (G_LATCH_DELAY > 1) ? S_HOLD : S_IDLE;
          end
        end
        S_HOLD: begin
          // Leaving on the 1->0 step makes the next pop land exactly G_LATCH_DELAY after the last
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Debug core reset follows system reset, released one edge later
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) jrstn_o <= 1'b0;
    else          jrstn_o <= 1'b1;
  end
endmodule

// File: tb/tb_jtag_wb_bridge.sv
// Self-checking bench for jtag_wb_bridge (defaults: depth 4, latch delay 8, 8-bit data, 3-bit addr).
module tb_jtag_wb_bridge;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] reg_d;
  logic [2:0] reg_addr_d;
  logic       reg_update;
  logic [7:0] reg_q;
  logic [2:0] reg_addr_q;
  logic       jtck, jrstn;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  jtag_wb_bridge_if bus();

  jtag_wb_bridge #(.G_DEPTH(4), .G_LATCH_DELAY(8), .G_DATA_W(8), .G_ADDR_W(3)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus),
    .reg_d_i(reg_d), .reg_addr_d_i(reg_addr_d),
    .reg_update_o(reg_update), .reg_q_o(reg_q), .reg_addr_q_o(reg_addr_q),
    .jtck_o(jtck), .jrstn_o(jrstn)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct { int cyc; logic [7:0] d; logic [2:0] a; } upd_t;
  upd_t obs_q[$];
  upd_t exp_q[$];

  always @(negedge clk) begin
    if (reg_update === 1'b1) obs_q.push_back('{cyc: cyc_cnt, d: reg_q, a: reg_addr_q});
  end

  logic        op_we  [16];
  logic [31:0] op_adr [16];
  logic [31:0] op_dat [16];
  logic        res_ack[16];
  logic [31:0] res_dat[16];
  logic        tail_ack;
  logic [31:0] tail_dat;
  logic        any_stall;
  int          t0;

  task automatic set_op(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    op_we[i] = we; op_adr[i] = adr; op_dat[i] = dat;
  endtask

  // Back-to-back requests; op i is accepted in cycle t0+i
  task automatic wb_burst(input int n);
    @(posedge clk); #1;
    t0 = cyc_cnt;
    any_stall = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_sel_i = 4'hF;
      bus.wb_we_i = op_we[i]; bus.wb_adr_i = op_adr[i]; bus.wb_dat_i = op_dat[i];
      #1 any_stall = any_stall | bus.wb_stall_o;
      @(posedge clk); #1;
      res_ack[i] = bus.wb_ack_o;
      res_dat[i] = bus.wb_dat_o;
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    @(posedge clk); #1;
    tail_ack = bus.wb_ack_o;
    tail_dat = bus.wb_dat_o;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && obs_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
    if (obs_q.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    reg_d = 8'h00; reg_addr_d = 3'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.wb_ack_o, reg_update, reg_q, reg_addr_q, jrstn} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b upd=%b q=%h a=%h jrstn=%b required all 0",
               bus.wb_ack_o, reg_update, reg_q, reg_addr_q, jrstn);
    end
    checks++;
    if (jtck !== clk) begin failures++; $display("FAIL jtck: got %b required %b", jtck, clk); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    checks++;
    if (jrstn !== 1'b0) begin failures++; $display("FAIL jrstn_pre_edge: got %b required 0", jrstn); end
    @(posedge clk); #1;
    checks++;
    if (jrstn !== 1'b1) begin failures++; $display("FAIL jrstn_post_edge: got %b required 1", jrstn); end
    set_op(0, 1'b0, 32'h4, 32'h0);
    wb_burst(1);
    checks++;
    if (res_ack[0] !== 1'b1 || res_dat[0] !== 32'h1) begin
      failures++; $display("FAIL reset_status: got ack=%b dat=%h required ack=1 dat=00000001", res_ack[0], res_dat[0]);
    end
    checks++;
    if (tail_ack !== 1'b0 || tail_dat !== 32'h0) begin
      failures++; $display("FAIL ack_one_cycle: got ack=%b dat=%h required 0/00000000", tail_ack, tail_dat);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    upd_t e, o;
    obs_q.delete(); exp_q.delete();
    set_op(0, 1'b1, 32'h0, 32'h0000_02AD);
    wb_burst(1);
    exp_q.push_back('{cyc: t0 + 2, d: 8'h55, a: 3'h5});
    checks++;
    if (res_ack[0] !== 1'b1) begin failures++; $display("FAIL single_ack: got %b required 1", res_ack[0]); end
    wait_obs(1, 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: got %0d updates required 1", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL single_upd: got none required cyc=%0d q=%h a=%h", e.cyc, e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.d !== e.d || o.a !== e.a) begin
          failures++;
          $display("FAIL single_upd: got cyc=%0d q=%h a=%h required cyc=%0d q=%h a=%h", o.cyc, o.d, o.a, e.cyc, e.d, e.a);
        end
      end
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (reg_q !== 8'h55 || reg_addr_q !== 3'h5 || reg_update !== 1'b0) begin
      failures++; $display("FAIL single_hold: got q=%h a=%h upd=%b required 55/5/0", reg_q, reg_addr_q, reg_update);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    upd_t e, o;
    logic [7:0] d;
    logic [2:0] a;
    repeat (12) @(posedge clk);
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      a = 3'($urandom_range(0, 7));
      set_op(i, 1'b1, 32'h0, (32'(d) << 3) | 32'(a));
      exp_q.push_back('{cyc: i * 8 + 2, d: d, a: a});
    end
    wb_burst(4);
    for (int i = 0; i < 4; i++) exp_q[i].cyc = exp_q[i].cyc + t0;
    checks++;
    if (any_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall: got %b required 0", any_stall); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_ack[i] !== 1'b1) begin failures++; $display("FAIL b2b_ack%0d: got %b required 1", i, res_ack[i]); end
    end
    wait_obs(4, 60, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_timeout: got %0d updates required 4", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL b2b_upd: got none required cyc=%0d q=%h a=%h", e.cyc, e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.d !== e.d || o.a !== e.a) begin
          failures++;
          $display("FAIL b2b_upd: got cyc=%0d q=%h a=%h required cyc=%0d q=%h a=%h", o.cyc, o.d, o.a, e.cyc, e.d, e.a);
        end
      end
    end
  endtask

  task automatic test_map();
    repeat (12) @(posedge clk);
    obs_q.delete();
    reg_d = 8'hA5; reg_addr_d = 3'h3;
    repeat (2) @(posedge clk);
    set_op(0, 1'b0, 32'h0, 32'h0);
    set_op(1, 1'b0, 32'h8, 32'h0);
    set_op(2, 1'b0, 32'hC, 32'h0);
    set_op(3, 1'b1, 32'h8, 32'h0000_02AD);
    set_op(4, 1'b1, 32'hC, 32'h0000_02AD);
    wb_burst(5);
    checks++;
    if (res_dat[0] !== 32'h0000_052B) begin failures++; $display("FAIL cmd_read: got %h required 0000052b", res_dat[0]); end
    checks++;
    if (res_dat[1] !== 32'h0 || res_dat[2] !== 32'h0) begin
      failures++; $display("FAIL unmapped_read: got %h %h required 0 0", res_dat[1], res_dat[2]);
    end
    checks++;
    if ({res_ack[0], res_ack[1], res_ack[2], res_ack[3], res_ack[4]} !== 5'b11111) begin
      failures++; $display("FAIL map_acks: got %b%b%b%b%b required 11111", res_ack[0], res_ack[1], res_ack[2], res_ack[3], res_ack[4]);
    end
    reg_d = 8'h00; reg_addr_d = 3'h0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL unmapped_write: got %0d updates required 0", obs_q.size()); end
    set_op(0, 1'b0, 32'h0, 32'h0);
    set_op(1, 1'b0, 32'h4, 32'h0);
    wb_burst(2);
    checks++;
    if (res_dat[0] !== 32'h0 || res_dat[1] !== 32'h1) begin
      failures++; $display("FAIL map_idle: got cmd=%h status=%h required 0/00000001", res_dat[0], res_dat[1]);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    upd_t e, o;
    logic [7:0] d;
    repeat (12) @(posedge clk);
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 7; i++) begin
      d = 8'h30 + 8'(i);
      set_op(i, 1'b1, 32'h0, (32'(d) << 3) | 32'(i));
      if (i < 5) exp_q.push_back('{cyc: (i == 0) ? 2 : 8 * i + 2, d: d, a: 3'(i)});
    end
    set_op(7, 1'b0, 32'h4, 32'h0);
    set_op(8, 1'b1, 32'h4, 32'h4);
    set_op(9, 1'b0, 32'h4, 32'h0);
    wb_burst(10);
    for (int i = 0; i < exp_q.size(); i++) exp_q[i].cyc = exp_q[i].cyc + t0;
    checks++;
    if (res_ack[5] !== 1'b1 || res_ack[6] !== 1'b1) begin
      failures++; $display("FAIL drop_ack: got %b %b required 1 1", res_ack[5], res_ack[6]);
    end
    checks++;
    if (res_dat[7] !== 32'h0000_0406) begin failures++; $display("FAIL ovf_status: got %h required 00000406", res_dat[7]); end
    checks++;
    if (res_dat[9] !== 32'h0000_0402) begin failures++; $display("FAIL ovf_clear: got %h required 00000402", res_dat[9]); end
    wait_obs(5, 80, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ovf_timeout: got %0d updates required 5", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL ovf_upd: got none required cyc=%0d q=%h a=%h", e.cyc, e.d, e.a);
      end else begin
        o = obs_q.pop_front();
        if (o.cyc !== e.cyc || o.d !== e.d || o.a !== e.a) begin
          failures++;
          $display("FAIL ovf_upd: got cyc=%0d q=%h a=%h required cyc=%0d q=%h a=%h", o.cyc, o.d, o.a, e.cyc, e.d, e.a);
        end
      end
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL ovf_extra: got %0d extra updates required 0", obs_q.size()); end
    set_op(0, 1'b0, 32'h4, 32'h0);
    wb_burst(1);
    checks++;
    if (res_dat[0] !== 32'h1) begin failures++; $display("FAIL ovf_drained: got %h required 00000001", res_dat[0]); end
  endtask

  task automatic test_reset_mid();
    upd_t o;
    repeat (12) @(posedge clk);
    obs_q.delete();
    set_op(0, 1'b1, 32'h0, 32'h0000_03F7);
    set_op(1, 1'b1, 32'h0, 32'h0000_0111);
    set_op(2, 1'b1, 32'h0, 32'h0000_0222);
    set_op(3, 1'b1, 32'h0, 32'h0000_0333);
    wb_burst(4);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wb_ack_o, reg_update, reg_q, reg_addr_q, jrstn} !== 14'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got ack=%b upd=%b q=%h a=%h jrstn=%b required all 0",
               bus.wb_ack_o, reg_update, reg_q, reg_addr_q, jrstn);
    end
    checks++;
    if (obs_q.size() != 1) begin
      failures++; $display("FAIL mid_first_upd: got %0d updates required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o.cyc !== t0 + 2 || o.d !== 8'h7E || o.a !== 3'h7) begin
        failures++; $display("FAIL mid_first_upd: got cyc=%0d q=%h a=%h required cyc=%0d q=7e a=7", o.cyc, o.d, o.a, t0 + 2);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL mid_no_update: got %0d updates required 0", obs_q.size()); end
    checks++;
    if (reg_q !== 8'h00 || reg_addr_q !== 3'h0) begin
      failures++; $display("FAIL mid_hold_zero: got q=%h a=%h required 00/0", reg_q, reg_addr_q);
    end
    set_op(0, 1'b0, 32'h4, 32'h0);
    wb_burst(1);
    checks++;
    if (res_dat[0] !== 32'h1) begin failures++; $display("FAIL mid_status: got %h required 00000001", res_dat[0]); end
  endtask

`ifdef JTAG_WB_SNAPSHOT_EN
  task automatic test_snapshot();
    reg_d = 8'h00; reg_addr_d = 3'h0;
    repeat (3) @(posedge clk);
    set_op(0, 1'b0, 32'h0, 32'h0);
    set_op(1, 1'b0, 32'h4, 32'h0);
    wb_burst(2);
    checks++;
    if (res_dat[1] !== 32'h1) begin failures++; $display("FAIL snap_quiet: got %h required 00000001", res_dat[1]); end
    reg_d = 8'h12;
    repeat (3) @(posedge clk);
    set_op(0, 1'b0, 32'h4, 32'h0);
    set_op(1, 1'b0, 32'h0, 32'h0);
    set_op(2, 1'b0, 32'h4, 32'h0);
    wb_burst(3);
    checks++;
    if (res_dat[0] !== 32'h9) begin failures++; $display("FAIL snap_changed: got %h required 00000009", res_dat[0]); end
    checks++;
    if (res_dat[1] !== 32'h90) begin failures++; $display("FAIL snap_cmd: got %h required 00000090", res_dat[1]); end
    checks++;
    if (res_dat[2] !== 32'h1) begin failures++; $display("FAIL snap_cleared: got %h required 00000001", res_dat[2]); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_map();
    test_overflow();
    test_reset_mid();
`ifdef JTAG_WB_SNAPSHOT_EN
    test_snapshot();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
